// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a 32-bit word memory, with independent write (AW/W/B) and read (AR/R) engines.
// Define AXI_SLV_WRAP_EN to accept WRAP bursts; without it, WRAP bursts are answered with SLVERR.
module axi4_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 12,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  s_axi_aclk_in,
  input  logic                  s_axi_areset_in,
  input  logic [ID_WIDTH-1:0]   s_axi_awid_in,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr_in,
  input  logic [7:0]            s_axi_awlen_in,
  input  logic [2:0]            s_axi_awsize_in,
  input  logic [1:0]            s_axi_awburst_in,
  input  logic                  s_axi_awvalid_in,
  output logic                  s_axi_awready_out,
  input  logic [31:0]           s_axi_wdata_in,
  input  logic [3:0]            s_axi_wstrb_in,
  input  logic                  s_axi_wlast_in,
  input  logic                  s_axi_wvalid_in,
  output logic                  s_axi_wready_out,
  output logic [ID_WIDTH-1:0]   s_axi_bid_out,
  output logic [1:0]            s_axi_bresp_out,
  output logic                  s_axi_bvalid_out,
  input  logic                  s_axi_bready_in,
  input  logic [ID_WIDTH-1:0]   s_axi_arid_in,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr_in,
  input  logic [7:0]            s_axi_arlen_in,
  input  logic [2:0]            s_axi_arsize_in,
  input  logic [1:0]            s_axi_arburst_in,
  input  logic                  s_axi_arvalid_in,
  output logic                  s_axi_arready_out,
  output logic [ID_WIDTH-1:0]   s_axi_rid_out,
  output logic [31:0]           s_axi_rdata_out,
  output logic [1:0]            s_axi_rresp_out,
  output logic                  s_axi_rlast_out,
  output logic                  s_axi_rvalid_out,
  input  logic                  s_axi_rready_in
);

`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [IDX_W-1:0]      idx_t;

  localparam addr_t      MEM_BYTES   = addr_t'(4 * MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  function automatic logic in_range(addr_t a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  function automatic idx_t mem_index(addr_t a);
    return idx_t'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic burst_legal(logic [2:0] size, logic [1:0] burst, logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size == 3'b010) &&
           ((burst == BURST_FIXED) || (burst == BURST_INCR) ||
            (WRAP_EN && (burst == BURST_WRAP) && wrap_len_ok));
  endfunction

  // WRAP keeps the address inside a (len+1)*4-byte aligned window; len*4+3 is that window's mask.
  function automatic addr_t next_addr(addr_t a, logic [1:0] burst, logic [7:0] len);
    addr_t mask;
    mask = (addr_t'(len) << 2) | addr_t'(3);
    if (burst == BURST_FIXED) return a;
    if (WRAP_EN && (burst == BURST_WRAP)) return (a & ~mask) | ((a + addr_t'(4)) & mask);
    return a + addr_t'(4);
  endfunction

  logic [31:0] mem [MEM_DEPTH];

  // ---------------- write engine ----------------
  wstate_t             wstate_q, wstate_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d, wburst_q, wburst_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  addr_t               waddr_q, waddr_d;
  logic [7:0]          wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic                wlegal_q, wlegal_d, wdec_q, wdec_d, wslv_q, wslv_d;
  logic                mem_we, beat_dec, beat_slv, aw_legal;

  // NOTE: always_comb uses blocking assignments and sets every output to a default first, so no latch is inferred.
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wburst_d  = wburst_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    wlegal_d  = wlegal_q;
    wdec_d    = wdec_q;
    wslv_d    = wslv_q;
    mem_we    = 1'b0;
    beat_dec  = 1'b0;
    beat_slv  = 1'b0;
    aw_legal  = burst_legal(s_axi_awsize_in, s_axi_awburst_in, s_axi_awlen_in);
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && s_axi_awvalid_in) begin
          wid_d     = s_axi_awid_in;
          waddr_d   = s_axi_awaddr_in;
          wlen_d    = s_axi_awlen_in;
          wburst_d  = s_axi_awburst_in;
          wbeat_d   = '0;
          wlegal_d  = aw_legal;
          wdec_d    = 1'b0;
          wslv_d    = !aw_legal;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (wready_q && s_axi_wvalid_in) begin
          beat_dec = !in_range(waddr_q);
          beat_slv = s_axi_wlast_in != (wbeat_q == wlen_q);
          mem_we   = wlegal_q && !beat_dec;
          waddr_d  = next_addr(waddr_q, wburst_q, wlen_q);
          wbeat_d  = wbeat_q + 8'd1;
          wdec_d   = wdec_q | beat_dec;
          wslv_d   = wslv_q | beat_slv;
          if (wbeat_q == wlen_q) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (wdec_q | beat_dec) ? RESP_DECERR :
                       (wslv_q | beat_slv) ? RESP_SLVERR : RESP_OKAY;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready_in) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk_in or posedge s_axi_areset_in) begin
    if (s_axi_areset_in) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wburst_q  <= BURST_FIXED;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wlegal_q  <= 1'b0;
      wdec_q    <= 1'b0;
      wslv_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wburst_q  <= wburst_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      wlegal_q  <= wlegal_d;
      wdec_q    <= wdec_d;
      wslv_q    <= wslv_d;
    end
  end

  // NOTE: the memory array is deliberately not reset; contents survive reset and the array can map onto RAM.
  always_ff @(posedge s_axi_aclk_in) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb_in[b]) mem[mem_index(waddr_q)][8*b +: 8] <= s_axi_wdata_in[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rstate_t             rstate_q, rstate_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d, rburst_q, rburst_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  addr_t               raddr_q, raddr_d;
  logic [7:0]          rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic                rlegal_q, rlegal_d;
  logic                ld, ld_legal;

  // Each beat's data is fetched into rdata_q when the beat is launched, so a same-cycle write is not seen.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rburst_d  = rburst_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rlegal_d  = rlegal_q;
    ld        = 1'b0;
    ld_legal  = rlegal_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && s_axi_arvalid_in) begin
          rid_d     = s_axi_arid_in;
          raddr_d   = s_axi_araddr_in;
          rlen_d    = s_axi_arlen_in;
          rburst_d  = s_axi_arburst_in;
          rlegal_d  = burst_legal(s_axi_arsize_in, s_axi_arburst_in, s_axi_arlen_in);
          rbeat_d   = '0;
          rlast_d   = (s_axi_arlen_in == 8'd0);
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          ld        = 1'b1;
          ld_legal  = rlegal_d;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready_in) begin
          if (rbeat_q == rlen_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
            ld      = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (ld) begin
      if (!ld_legal) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (!in_range(raddr_d)) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = mem[mem_index(raddr_d)];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge s_axi_aclk_in or posedge s_axi_areset_in) begin
    if (s_axi_areset_in) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rburst_q  <= BURST_FIXED;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rlegal_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rburst_q  <= rburst_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rlegal_q  <= rlegal_d;
    end
  end

  assign s_axi_awready_out = awready_q;
  assign s_axi_wready_out  = wready_q;
  assign s_axi_bid_out     = wid_q;
  assign s_axi_bresp_out   = bresp_q;
  assign s_axi_bvalid_out  = bvalid_q;
  assign s_axi_arready_out = arready_q;
  assign s_axi_rid_out     = rid_q;
  assign s_axi_rdata_out   = rdata_q;
  assign s_axi_rresp_out   = rresp_q;
  assign s_axi_rlast_out   = rlast_q;
  assign s_axi_rvalid_out  = rvalid_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: tasks drive directed AXI transfers and push expected B/R responses,
// a negedge monitor compares every presented response against the queue heads.
module tb_axi4_slave_mem;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi4_slave_mem dut (
    .s_axi_aclk_in(clk), .s_axi_areset_in(rst),
    .s_axi_awid_in(awid), .s_axi_awaddr_in(awaddr), .s_axi_awlen_in(awlen),
    .s_axi_awsize_in(awsize), .s_axi_awburst_in(awburst), .s_axi_awvalid_in(awvalid),
    .s_axi_awready_out(awready),
    .s_axi_wdata_in(wdata), .s_axi_wstrb_in(wstrb), .s_axi_wlast_in(wlast),
    .s_axi_wvalid_in(wvalid), .s_axi_wready_out(wready),
    .s_axi_bid_out(bid), .s_axi_bresp_out(bresp), .s_axi_bvalid_out(bvalid), .s_axi_bready_in(bready),
    .s_axi_arid_in(arid), .s_axi_araddr_in(araddr), .s_axi_arlen_in(arlen),
    .s_axi_arsize_in(arsize), .s_axi_arburst_in(arburst), .s_axi_arvalid_in(arvalid),
    .s_axi_arready_out(arready),
    .s_axi_rid_out(rid), .s_axi_rdata_out(rdata), .s_axi_rresp_out(rresp),
    .s_axi_rlast_out(rlast), .s_axi_rvalid_out(rvalid), .s_axi_rready_in(rready)
  );

  typedef struct packed {logic [11:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [11:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] wbuf [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_spurious", 64'(bvalid), 64'd0);
        else begin
          b_exp_t eb;
          eb = bq.pop_front();
          check("bid", 64'(bid), 64'(eb.id));
          check("bresp", 64'(bresp), 64'(eb.resp));
        end
      end
      if (rvalid) begin
        check("arready_busy", 64'(arready), 64'd0);
        if (rq.size() == 0) check("r_spurious", 64'(rvalid), 64'd0);
        else begin
          r_exp_t er;
          er = rq[0];
          check("rid", 64'(rid), 64'(er.id));
          check("rdata", 64'(rdata), 64'(er.data));
          check("rresp", 64'(rresp), 64'(er.resp));
          check("rlast", 64'(rlast), 64'(er.last));
          if (rready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic push_r(input logic [11:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic send_aw(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit got = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (awready) begin got = 1; break; end
    end
    if (!got) check("aw_timeout", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit got = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin got = 1; break; end
    end
    if (!got) check("ar_timeout", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len, input logic [3:0] strb, input int last_beat);
    for (int b = 0; b <= int'(len); b++) begin
      bit got = 0;
      wdata = wbuf[b]; wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (wready) begin got = 1; break; end
      end
      if (!got) check("w_timeout", 64'(wready), 64'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      @(posedge clk); #1;
    end
    check({name, "_drain"}, 64'(bq.size() + rq.size()), 64'd0);
  endtask

  task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int last_beat, input logic [1:0] exp_resp);
    b_exp_t e;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    send_aw(id, addr, len, size, burst);
    send_w(len, strb, last_beat);
    wait_drain("write");
  endtask

  task automatic write1(input logic [11:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    wbuf[0] = data;
    do_write(id, addr, 8'd0, 3'd2, INCR, strb, 0, exp_resp);
  endtask

  task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    send_ar(id, addr, len, size, burst);
    wait_drain("read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("awready_pre", 64'(awready), 64'd0);
    @(negedge clk);
    check("awready_post", 64'(awready), 64'd1);
    check("arready_post", 64'(arready), 64'd1);
    @(posedge clk); #1;

    // single write/read
    write1(12'h5, 32'h10, 32'hDEAD_BEEF, 4'hF, OKAY);
    push_r(12'h3, 32'hDEAD_BEEF, OKAY, 1'b1);
    do_read(12'h3, 32'h10, 8'd0, 3'd2, INCR);

    // INCR burst plus partial-strobe overwrite
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(12'h1, 32'h100, 8'd3, 3'd2, INCR, 4'hF, 3, OKAY);
    write1(12'h2, 32'h104, 32'hFFFF_FFFF, 4'h3, OKAY);
    push_r(12'h4, 32'h1, OKAY, 1'b0);
    push_r(12'h4, 32'h0000_FFFF, OKAY, 1'b0);
    push_r(12'h4, 32'h3, OKAY, 1'b0);
    push_r(12'h4, 32'h4, OKAY, 1'b1);
    do_read(12'h4, 32'h100, 8'd3, 3'd2, INCR);

    // FIXED burst re-reads the same word
    for (int i = 0; i < 3; i++) push_r(12'h6, 32'hDEAD_BEEF, OKAY, i == 2);
    do_read(12'h6, 32'h10, 8'd2, 3'd2, FIXED);

    // len 7 read with rready toggling
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA5A5_0000 + 32'(i);
    do_write(12'h7, 32'h300, 8'd7, 3'd2, INCR, 4'hF, 7, OKAY);
    for (int i = 0; i < 8; i++) push_r(12'h8, 32'hA5A5_0000 + 32'(i), OKAY, i == 7);
    rready = 1'b0;
    send_ar(12'h8, 32'h300, 8'd7, 3'd2, INCR);
    for (int i = 0; i < 64 && rq.size() != 0; i++) begin
      @(posedge clk); #1;
      rready = ~rready;
    end
    rready = 1'b1;
    wait_drain("stall");

    // out-of-range write must not alias onto word 0; last word is in range
    write1(12'h9, 32'h0, 32'h1111_1111, 4'hF, OKAY);
    write1(12'h9, 32'h1000, 32'h2222_2222, 4'hF, DECERR);
    push_r(12'hA, 32'h1111_1111, OKAY, 1'b1);
    do_read(12'hA, 32'h0, 8'd0, 3'd2, INCR);
    push_r(12'hA, 32'h0, DECERR, 1'b1);
    do_read(12'hA, 32'h1000, 8'd0, 3'd2, INCR);
    write1(12'hB, 32'hFFC, 32'hCAFE_F00D, 4'hF, OKAY);
    push_r(12'hB, 32'hCAFE_F00D, OKAY, 1'b1);
    do_read(12'hB, 32'hFFC, 8'd0, 3'd2, INCR);

    // early wlast and illegal size
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h4000 + 32'(i);
    do_write(12'hC, 32'h400, 8'd3, 3'd2, INCR, 4'hF, 1, SLVERR);
    write1(12'hD, 32'h500, 32'h1234_5678, 4'hF, OKAY);
    wbuf[0] = 32'h55;
    do_write(12'hD, 32'h500, 8'd0, 3'd1, INCR, 4'hF, 0, SLVERR);
    push_r(12'hE, 32'h1234_5678, OKAY, 1'b1);
    do_read(12'hE, 32'h500, 8'd0, 3'd2, INCR);
    push_r(12'hE, 32'h0, SLVERR, 1'b1);
    do_read(12'hE, 32'h500, 8'd0, 3'd1, INCR);

    // WRAP len 3 at 0x208
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0C0_0000 + 32'(i);
    do_write(12'hF, 32'h200, 8'd3, 3'd2, INCR, 4'hF, 3, OKAY);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
`ifdef AXI_SLV_WRAP_EN
    wbuf[0] = 32'hC0C0_0002; wbuf[1] = 32'hC0C0_0003; wbuf[2] = 32'hC0C0_0000; wbuf[3] = 32'hC0C0_0001;
    do_write(12'hF, 32'h208, 8'd3, 3'd2, WRAP, 4'hF, 3, OKAY);
    push_r(12'h10, 32'hC0C0_0002, OKAY, 1'b0);
    push_r(12'h10, 32'hC0C0_0003, OKAY, 1'b0);
    push_r(12'h10, 32'hC0C0_0000, OKAY, 1'b0);
    push_r(12'h10, 32'hC0C0_0001, OKAY, 1'b1);
`else
    do_write(12'hF, 32'h208, 8'd3, 3'd2, WRAP, 4'hF, 3, SLVERR);
    for (int i = 0; i < 4; i++) push_r(12'h10, 32'h0, SLVERR, i == 3);
`endif
    do_read(12'h10, 32'h208, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) push_r(12'h11, 32'hC0C0_0000 + 32'(i), OKAY, i == 3);
    do_read(12'h11, 32'h200, 8'd3, 3'd2, INCR);

    // reset while beat 2 of 8 is presented, then a fresh burst
    for (int i = 0; i < 8; i++) push_r(12'h12, 32'hA5A5_0000 + 32'(i), OKAY, i == 7);
    send_ar(12'h12, 32'h300, 8'd7, 3'd2, INCR);
    begin
      bit got = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        if (rq.size() == 6) begin got = 1; break; end
      end
      if (!got) check("midburst_timeout", 64'(rq.size()), 64'd6);
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_rlast", 64'(rlast), 64'd0);
    check("midrst_arready", 64'(arready), 64'd0);
    rq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_r(12'h13, 32'hA5A5_0000, OKAY, 1'b0);
    push_r(12'h13, 32'hA5A5_0001, OKAY, 1'b1);
    do_read(12'h13, 32'h300, 8'd1, 3'd2, INCR);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
